// File: rtl/ex_ctrl.sv
// Writeback exception/interrupt controller: prioritises exception causes, drives the
// CSR exception/ERTN commit strobes, flushes the pipeline and holds a fetch redirect.
module ex_ctrl #(
  parameter int unsigned DRAIN_CYCLES = 0,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             wb_valid,
  input  logic [31:0]      wb_pc,
  input  logic [4:0]       wb_ex_src,
  input  logic [31:0]      wb_badv,
  input  logic             wb_ertn,
  input  logic             crmd_ie,
  input  logic [12:0]      ecfg_lie,
  input  logic [12:0]      estat_is,
  input  logic [31:0]      ex_entry,
  input  logic [31:0]      era,
  input  logic             redir_ready,
  output logic             csr_wb_ex,
  output logic [5:0]       csr_wb_ecode,
  output logic [8:0]       csr_wb_esubcode,
  output logic [31:0]      csr_wb_pc,
  output logic [31:0]      csr_wb_vaddr,
  output logic             csr_ertn_flush,
  output logic             flush_all,
  output logic             commit_block,
  output logic             redir_valid,
  output logic [31:0]      redir_pc,
  output logic [CNT_W-1:0] ex_count
);

  typedef enum logic [1:0] {RUN, REDIR, DRAIN} state_t;

  localparam logic [5:0] ECODE_INT  = 6'h00;
  localparam logic [5:0] ECODE_ADEF = 6'h08;
  localparam logic [5:0] ECODE_ALE  = 6'h09;
  localparam logic [5:0] ECODE_SYS  = 6'h0B;
  localparam logic [5:0] ECODE_BRK  = 6'h0C;
  localparam logic [5:0] ECODE_INE  = 6'h0D;

  localparam logic [3:0] DRAIN_INIT = (DRAIN_CYCLES == 0) ? 4'd0 : 4'(DRAIN_CYCLES - 1);

  state_t           state, state_nxt;
  logic [3:0]       drain_cnt, drain_cnt_nxt;
  logic             redir_valid_nxt, commit_block_nxt;
  logic [31:0]      redir_pc_nxt;
  logic [CNT_W-1:0] ex_count_nxt;

  logic int_pend, take, ret;

  assign int_pend = crmd_ie & (|(ecfg_lie & estat_is));
  assign take     = (state == RUN) & wb_valid & (int_pend | (|wb_ex_src));
  assign ret      = (state == RUN) & wb_valid & wb_ertn & ~take;

  assign csr_wb_ex       = take;
  assign csr_wb_esubcode = 9'd0;
  assign csr_wb_pc       = take ? wb_pc : 32'd0;
  assign csr_ertn_flush  = ret;
  assign flush_all       = take | ret;

  // Cause priority: interrupt first, then the source flags from bit 0 upward.
  always_comb begin
    // NOTE: every output gets a default before the branches so no latch is inferred.
    csr_wb_ecode = 6'd0;
    csr_wb_vaddr = 32'd0;
    if (take) begin
      if (int_pend) begin
        csr_wb_ecode = ECODE_INT;
      end else if (wb_ex_src[0]) begin
        csr_wb_ecode = ECODE_ADEF;
        csr_wb_vaddr = wb_pc;
      end else if (wb_ex_src[1]) begin
        csr_wb_ecode = ECODE_INE;
      end else if (wb_ex_src[2]) begin
        csr_wb_ecode = ECODE_SYS;
      end else if (wb_ex_src[3]) begin
        csr_wb_ecode = ECODE_BRK;
      end else begin
        csr_wb_ecode = ECODE_ALE;
        csr_wb_vaddr = wb_badv;
      end
    end
  end

  always_comb begin
    state_nxt        = state;
    drain_cnt_nxt    = drain_cnt;
    redir_valid_nxt  = redir_valid;
    redir_pc_nxt     = redir_pc;
    commit_block_nxt = commit_block;
    case (state)
      RUN: begin
        if (take | ret) begin
          state_nxt        = REDIR;
          redir_valid_nxt  = 1'b1;
          commit_block_nxt = 1'b1;
          redir_pc_nxt     = take ? ex_entry : era;
        end
      end
      REDIR: begin
        if (redir_ready) begin
          redir_valid_nxt = 1'b0;
          if (DRAIN_CYCLES == 0) begin
            state_nxt        = RUN;
            commit_block_nxt = 1'b0;
          end else begin
            state_nxt     = DRAIN;
            drain_cnt_nxt = DRAIN_INIT;
          end
        end
      end
      DRAIN: begin
        if (drain_cnt == 4'd0) begin
          state_nxt        = RUN;
          commit_block_nxt = 1'b0;
        end else begin
          drain_cnt_nxt = drain_cnt - 4'd1;
        end
      end
      default: begin
        state_nxt        = RUN;
        redir_valid_nxt  = 1'b0;
        commit_block_nxt = 1'b0;
      end
    endcase
  end

  assign ex_count_nxt = (take && (ex_count != {CNT_W{1'b1}})) ? ex_count + CNT_W'(1) : ex_count;

  // NOTE: reset is synchronous and active-low, so it is only tested inside the clocked branch.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state        <= RUN;
      drain_cnt    <= 4'd0;
      redir_valid  <= 1'b0;
      redir_pc     <= 32'd0;
      commit_block <= 1'b0;
      ex_count     <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
      state        <= state_nxt;
      drain_cnt    <= drain_cnt_nxt;
      redir_valid  <= redir_valid_nxt;
      redir_pc     <= redir_pc_nxt;
      commit_block <= commit_block_nxt;
      ex_count     <= ex_count_nxt;
    end
  end

endmodule

// File: tb/tb_ex_ctrl.sv
// Scoreboard bench for ex_ctrl: two instances (no drain / 3-cycle drain with a narrow
// counter) share stimulus; a behavioural model predicts each cycle's outputs.
module tb_ex_ctrl;

  logic        clk = 1'b0;
  logic        resetn, wb_valid, wb_ertn, crmd_ie, redir_ready;
  logic [31:0] wb_pc, wb_badv, ex_entry, era;
  logic [4:0]  wb_ex_src;
  logic [12:0] ecfg_lie, estat_is;

  logic        a_ex, a_ertn, a_flush, a_cb, a_rv;
  logic [5:0]  a_ecode;
  logic [8:0]  a_esub;
  logic [31:0] a_pc, a_vaddr, a_rpc;
  logic [15:0] a_cnt;
  logic        b_ex, b_ertn, b_flush, b_cb, b_rv;
  logic [5:0]  b_ecode;
  logic [8:0]  b_esub;
  logic [31:0] b_pc, b_vaddr, b_rpc;
  logic [3:0]  b_cnt;

  always #5 clk = ~clk;

  ex_ctrl #(.DRAIN_CYCLES(0), .CNT_W(16)) u_nodrain (
    .clk(clk), .resetn(resetn), .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_ex_src(wb_ex_src),
    .wb_badv(wb_badv), .wb_ertn(wb_ertn), .crmd_ie(crmd_ie), .ecfg_lie(ecfg_lie),
    .estat_is(estat_is), .ex_entry(ex_entry), .era(era), .redir_ready(redir_ready),
    .csr_wb_ex(a_ex), .csr_wb_ecode(a_ecode), .csr_wb_esubcode(a_esub), .csr_wb_pc(a_pc),
    .csr_wb_vaddr(a_vaddr), .csr_ertn_flush(a_ertn), .flush_all(a_flush),
    .commit_block(a_cb), .redir_valid(a_rv), .redir_pc(a_rpc), .ex_count(a_cnt));

  ex_ctrl #(.DRAIN_CYCLES(3), .CNT_W(4)) u_drain (
    .clk(clk), .resetn(resetn), .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_ex_src(wb_ex_src),
    .wb_badv(wb_badv), .wb_ertn(wb_ertn), .crmd_ie(crmd_ie), .ecfg_lie(ecfg_lie),
    .estat_is(estat_is), .ex_entry(ex_entry), .era(era), .redir_ready(redir_ready),
    .csr_wb_ex(b_ex), .csr_wb_ecode(b_ecode), .csr_wb_esubcode(b_esub), .csr_wb_pc(b_pc),
    .csr_wb_vaddr(b_vaddr), .csr_ertn_flush(b_ertn), .flush_all(b_flush),
    .commit_block(b_cb), .redir_valid(b_rv), .redir_pc(b_rpc), .ex_count(b_cnt));

  typedef struct {
    logic        ex;
    logic [5:0]  ecode;
    logic [8:0]  esub;
    logic [31:0] pc;
    logic [31:0] vaddr;
    logic        ertn;
    logic        flush;
    logic        cb;
    logic        rv;
    logic [31:0] rpc;
    logic [15:0] cnt;
  } obs_t;

  obs_t q0[$];
  obs_t q1[$];
  int   errors = 0;
  int   checks = 0;

  // Model: per instance, a pending redirect, a block flag and cycles of drain left.
  bit          m_pend[2];
  bit          m_blk[2];
  int          m_left[2];
  logic [31:0] m_tgt[2];
  int unsigned m_cnt[2];
  int          drain_len[2] = '{0, 3};
  int unsigned cnt_max[2]   = '{65535, 15};
  logic [5:0]  src_code[5]  = '{6'h08, 6'h0D, 6'h0B, 6'h0C, 6'h09};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic obs_t model_out(input int k);
    obs_t e;
    bit   intp, tk, rt;
    intp = crmd_ie && ((ecfg_lie & estat_is) != 13'd0);
    tk   = !m_blk[k] && wb_valid && (intp || wb_ex_src != 5'd0);
    rt   = !m_blk[k] && wb_valid && wb_ertn && !tk;
    e.ex = tk; e.ecode = 6'd0; e.esub = 9'd0; e.vaddr = 32'd0;
    e.pc = tk ? wb_pc : 32'd0;
    if (tk && !intp) begin
      for (int i = 4; i >= 0; i--) begin
        if (wb_ex_src[i]) e.ecode = src_code[i];
      end
      if (wb_ex_src[0]) e.vaddr = wb_pc;
      else if (wb_ex_src[3:1] == 3'd0) e.vaddr = wb_badv;
    end
    e.ertn = rt;
    e.flush = tk | rt;
    e.cb = m_blk[k];
    e.rv = m_pend[k];
    e.rpc = m_tgt[k];
    e.cnt = 16'(m_cnt[k]);
    return e;
  endfunction

  task automatic update_model();
    obs_t e;
    for (int k = 0; k < 2; k++) begin
      e = model_out(k);
      if (!resetn) begin
        m_pend[k] = 0; m_blk[k] = 0; m_left[k] = 0; m_tgt[k] = 32'd0; m_cnt[k] = 0;
      end else if (e.ex || e.ertn) begin
        m_pend[k] = 1; m_blk[k] = 1;
        m_tgt[k] = e.ex ? ex_entry : era;
        if (e.ex && m_cnt[k] < cnt_max[k]) m_cnt[k]++;
      end else if (m_pend[k] && redir_ready) begin
        m_pend[k] = 0;
        if (drain_len[k] == 0) m_blk[k] = 0;
        else m_left[k] = drain_len[k];
      end else if (m_left[k] > 0) begin
        m_left[k]--;
        if (m_left[k] == 0) m_blk[k] = 0;
      end
    end
  endtask

  // Issue the current inputs for one cycle: predict, then let the edge happen.
  task automatic step();
    q0.push_back(model_out(0));
    q1.push_back(model_out(1));
    @(posedge clk);
    update_model();
    #1;
  endtask

  task automatic idle_inputs();
    resetn = 1'b1; wb_valid = 1'b0; wb_ertn = 1'b0; wb_ex_src = 5'd0; crmd_ie = 1'b0;
    ecfg_lie = 13'd0; estat_is = 13'd0; redir_ready = 1'b1;
  endtask

  task automatic settle();
    idle_inputs();
    repeat (6) step();
  endtask

  task automatic compare(input string tag, input obs_t a, input obs_t e);
    check({tag, ".csr_wb_ex"}, 32'(a.ex), 32'(e.ex));
    check({tag, ".ecode"}, 32'(a.ecode), 32'(e.ecode));
    check({tag, ".esubcode"}, 32'(a.esub), 32'(e.esub));
    check({tag, ".csr_wb_pc"}, a.pc, e.pc);
    check({tag, ".vaddr"}, a.vaddr, e.vaddr);
    check({tag, ".ertn_flush"}, 32'(a.ertn), 32'(e.ertn));
    check({tag, ".flush_all"}, 32'(a.flush), 32'(e.flush));
    check({tag, ".commit_block"}, 32'(a.cb), 32'(e.cb));
    check({tag, ".redir_valid"}, 32'(a.rv), 32'(e.rv));
    check({tag, ".redir_pc"}, a.rpc, e.rpc);
    check({tag, ".ex_count"}, 32'(a.cnt), 32'(e.cnt));
  endtask

  // Monitor: pops one prediction per instance and compares mid-cycle.
  initial begin
    obs_t a, b;
    forever begin
      @(negedge clk);
      if (q0.size() > 0) begin
        a.ex = a_ex; a.ecode = a_ecode; a.esub = a_esub; a.pc = a_pc; a.vaddr = a_vaddr;
        a.ertn = a_ertn; a.flush = a_flush; a.cb = a_cb; a.rv = a_rv; a.rpc = a_rpc; a.cnt = a_cnt;
        compare("nodrain", a, q0.pop_front());
      end
      if (q1.size() > 0) begin
        b.ex = b_ex; b.ecode = b_ecode; b.esub = b_esub; b.pc = b_pc; b.vaddr = b_vaddr;
        b.ertn = b_ertn; b.flush = b_flush; b.cb = b_cb; b.rv = b_rv; b.rpc = b_rpc;
        b.cnt = 16'(b_cnt);
        compare("drain", b, q1.pop_front());
      end
    end
  end

  initial begin
    idle_inputs();
    wb_pc = 32'h1c000010; wb_badv = 32'h0; ex_entry = 32'h1c008000; era = 32'h1c000044;
    resetn = 1'b0;
    @(posedge clk); update_model(); #1;
    step();
    resetn = 1'b1;
    step();

    // SYS exception with same-cycle ready, then redirect held off for 5 cycles.
    wb_valid = 1'b1; wb_ex_src = 5'b00100; redir_ready = 1'b1;
    step();
    redir_ready = 1'b0;
    repeat (5) step();
    redir_ready = 1'b1;
    step();
    redir_ready = 1'b0;
    repeat (5) step();
    settle();

    // Interrupt beats ALE; then with IE clear, ALE reports the bad address.
    wb_valid = 1'b1; wb_ex_src = 5'b10000; wb_badv = 32'h0000_1233;
    crmd_ie = 1'b1; ecfg_lie = 13'h004; estat_is = 13'h004;
    step();
    settle();
    wb_valid = 1'b1; wb_ex_src = 5'b10000; ecfg_lie = 13'h004; estat_is = 13'h004;
    step();
    settle();

    // ERTN alone, then ERTN together with ADEF.
    wb_valid = 1'b1; wb_ertn = 1'b1;
    step();
    settle();
    wb_valid = 1'b1; wb_ertn = 1'b1; wb_ex_src = 5'b00001;
    step();
    settle();

    // Reset while a redirect is outstanding.
    wb_valid = 1'b1; wb_ex_src = 5'b01000; redir_ready = 1'b0;
    step();
    wb_valid = 1'b0; wb_ex_src = 5'd0;
    step();
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    repeat (2) step();

    // Enough takes to saturate the narrow counter.
    for (int i = 0; i < 20; i++) begin
      wb_valid = 1'b1; wb_ex_src = 5'b00010; redir_ready = 1'b0;
      step();
      wb_valid = 1'b0; wb_ex_src = 5'd0; redir_ready = 1'b1;
      repeat (4) step();
    end

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      resetn      = ($urandom_range(0, 299) != 0);
      wb_valid    = ($urandom_range(0, 3) != 0);
      wb_ex_src   = ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'd0;
      wb_ertn     = ($urandom_range(0, 3) == 0);
      crmd_ie     = $urandom_range(0, 1) == 1;
      ecfg_lie    = 13'($urandom);
      estat_is    = ($urandom_range(0, 3) == 0) ? 13'(1 << $urandom_range(0, 12)) : 13'd0;
      wb_pc       = $urandom;
      wb_badv     = $urandom;
      ex_entry    = $urandom;
      era         = $urandom;
      redir_ready = ($urandom_range(0, 2) == 0);
      step();
    end

    @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(q0.size() + q1.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
